aes_inv_mix_columns_seq: RTL and testbench

//  Iterative AES InvMixColumns unit for the decryption datapath; the inverse of the

---
 rtl/aes_pkg.sv | 31 +++
 rtl/aes_inv_mix_columns_seq_if.sv | 24 ++
 rtl/aes_inv_mix_column_word.sv | 36 +++
 rtl/aes_inv_mix_columns_seq.sv | 96 +++++++++
 tb/tb_aes_inv_mix_columns_seq.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) xtime helpers for the
// InvMixColumns datapath.
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_COL_W   = 32;
  localparam logic [7:0]  AES_POLY    = 8'h1b;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } aes_fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul4(input logic [7:0] b);
    return xtime(xtime(b));
  endfunction

  function automatic logic [7:0] gf_mul8(input logic [7:0] b);
    return xtime(xtime(xtime(b)));
  endfunction

endpackage

// File: rtl/aes_inv_mix_columns_seq_if.sv
// Handshake and data bus between the InvMixColumns unit and its neighbours.
// The slave modport is the unit's view; master is the upstream/downstream view.
interface aes_inv_mix_columns_seq_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_STATE_W-1:0] state_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_STATE_W-1:0] state_out;
  logic                   busy;

  modport slave (
    input  in_valid, state_in, out_ready,
    output in_ready, out_valid, state_out, busy
  );

  modport master (
    output in_valid, state_in, out_ready,
    input  in_ready, out_valid, state_out, busy
  );

endinterface

// File: rtl/aes_inv_mix_column_word.sv
// Combinational InvMixColumns of a single 32-bit column (s0 in the MSB byte).
// Constant multiplies are composed from x2/x4/x8 xtime chains.
module aes_inv_mix_column_word
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] col_i,
  output logic [AES_COL_W-1:0] col_o
);

  logic [7:0] s  [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s[i]  = col_i[31-8*i -: 8];
      x2[i] = gf_mul2(s[i]);
      x4[i] = gf_mul4(s[i]);
      x8[i] = gf_mul8(s[i]);
      m9[i] = x8[i] ^ s[i];
      mb[i] = x8[i] ^ x2[i] ^ s[i];
      md[i] = x8[i] ^ x4[i] ^ s[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    col_o = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
             m9[0] ^ me[1] ^ mb[2] ^ md[3],
             md[0] ^ m9[1] ^ me[2] ^ mb[3],
             mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  end

endmodule

// File: rtl/aes_inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: loads one state, rewrites COLS_PER_CYCLE columns
// in place per clock, then holds the result until downstream accepts it.
module aes_inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input logic                        clk,
  input logic                        rst,
  aes_inv_mix_columns_seq_if.slave   bus
);

  aes_fsm_e               fsm_q, fsm_d;
  logic [1:0]             col_cnt_q, col_cnt_d;
  logic [AES_STATE_W-1:0] data_q, data_d;

  logic [AES_COL_W-1:0]   cols     [4];
  logic [AES_COL_W-1:0]   cols_upd [4];
  logic [1:0]             col_idx  [COLS_PER_CYCLE];
  logic [AES_COL_W-1:0]   word_in  [COLS_PER_CYCLE];
  logic [AES_COL_W-1:0]   word_out [COLS_PER_CYCLE];
  logic                   last_step;

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      cols[c] = data_q[127-32*c -: 32];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx[g] = col_cnt_q + 2'(g);
    assign word_in[g] = cols[col_idx[g]];

    aes_inv_mix_column_word u_word (
      .col_i (word_in[g]),
      .col_o (word_out[g])
    );
  end

  always_comb begin
    cols_upd = cols;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      cols_upd[col_idx[g]] = word_out[g];
    end
  end

  // The step whose highest column index is 3 finishes the state.
  assign last_step = (col_cnt_q == 2'(4 - COLS_PER_CYCLE));

  always_comb begin
    fsm_d     = fsm_q;
    col_cnt_d = col_cnt_q;
    data_d    = data_q;
    unique case (fsm_q)
      IDLE: begin
        if (bus.in_valid) begin
          fsm_d     = BUSY;
          col_cnt_d = '0;
          data_d    = bus.state_in;
        end
      end
      BUSY: begin
        data_d    = {cols_upd[0], cols_upd[1], cols_upd[2], cols_upd[3]};
        col_cnt_d = col_cnt_q + 2'(COLS_PER_CYCLE);
        if (last_step) begin
          fsm_d     = DONE;
          col_cnt_d = '0;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q     <= IDLE;
      col_cnt_q <= '0;
      data_q    <= '0;
    end else begin
      fsm_q     <= fsm_d;
      col_cnt_q <= col_cnt_d;
      data_q    <= data_d;
    end
  end

  assign bus.in_ready  = (fsm_q == IDLE);
  assign bus.out_valid = (fsm_q == DONE);
  assign bus.busy      = (fsm_q != IDLE);
  assign bus.state_out = data_q;

endmodule

// File: tb/tb_aes_inv_mix_columns_seq.sv
// Directed bench for aes_inv_mix_columns_seq: known vectors, latency per
// COLS_PER_CYCLE, forward/inverse round trip, backpressure, reset, streaming.
module tb_aes_inv_mix_columns_seq;

  localparam logic [127:0] MIX_IN  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] MIX_OUT = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_inv_mix_columns_seq_if bus1 ();
  aes_inv_mix_columns_seq_if bus2 ();
  aes_inv_mix_columns_seq_if bus4 ();

  aes_inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  aes_inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  aes_inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward MixColumns of one column, used to build round-trip stimulus.
  function automatic logic [31:0] fwd_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  // Called at posedge+1 with dut1 idle; returns result and edges to out_valid.
  task automatic run_block(input logic [127:0] din, output logic [127:0] dout, output int lat);
    bus1.state_in = din;
    bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    lat = 0;
    while (!bus1.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    dout = bus1.state_out;
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  sv_in  [4];
    logic [31:0]  sv_out [4];
    logic [127:0] bb_in  [5];
    logic [127:0] bb_exp [5];
    logic [127:0] dout, orig, fwd, snap;
    logic [127:0] d1, d2, d4;
    int lat, l1, l2, l4;
    int in_idx, out_idx, cyc, last_cyc;
    logic hs, acc;

    sv_in[0] = 32'h8e4da1bc; sv_out[0] = 32'hdb135345;
    sv_in[1] = 32'h9fdc589d; sv_out[1] = 32'hf20a225c;
    sv_in[2] = 32'h01010101; sv_out[2] = 32'h01010101;
    sv_in[3] = 32'hc6c6c6c6; sv_out[3] = 32'hc6c6c6c6;

    rst = 1'b1;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.state_in = '0;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.state_in = '0;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.state_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus1.in_ready, 1'b1);
    check("rst_out_valid", bus1.out_valid, 1'b0);
    check("rst_busy", bus1.busy, 1'b0);
    check("rst_state_out", bus1.state_out, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-column vectors replicated in every column.
    for (int i = 0; i < 4; i++) begin
      run_block({4{sv_in[i]}}, dout, lat);
      check($sformatf("col_vec%0d", i), dout, {4{sv_out[i]}});
      check($sformatf("col_lat%0d", i), lat, 4);
    end

    // Mixed state on all three widths at once.
    bus1.state_in = MIX_IN; bus2.state_in = MIX_IN; bus4.state_in = MIX_IN;
    bus1.in_valid = 1'b1; bus2.in_valid = 1'b1; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0; bus2.in_valid = 1'b0; bus4.in_valid = 1'b0;
    l1 = -1; l2 = -1; l4 = -1;
    d1 = '0; d2 = '0; d4 = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (bus1.out_valid && l1 < 0) begin l1 = c; d1 = bus1.state_out; end
      if (bus2.out_valid && l2 < 0) begin l2 = c; d2 = bus2.state_out; end
      if (bus4.out_valid && l4 < 0) begin l4 = c; d4 = bus4.state_out; end
    end
    check("mix_lat_cpc1", l1, 4);
    check("mix_lat_cpc2", l2, 2);
    check("mix_lat_cpc4", l4, 1);
    check("mix_out_cpc1", d1, MIX_OUT);
    check("mix_out_cpc2", d2, MIX_OUT);
    check("mix_out_cpc4", d4, MIX_OUT);
    bus1.out_ready = 1'b1; bus2.out_ready = 1'b1; bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0; bus2.out_ready = 1'b0; bus4.out_ready = 1'b0;
    check("mix_idle_cpc2", bus2.in_ready, 1'b1);
    check("mix_idle_cpc4", bus4.in_ready, 1'b1);

    // Round trip through the bench's forward MixColumns.
    for (int k = 0; k < 1000; k++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      fwd  = {fwd_col(orig[127:96]), fwd_col(orig[95:64]),
              fwd_col(orig[63:32]), fwd_col(orig[31:0])};
      run_block(fwd, dout, lat);
      check("roundtrip", dout, orig);
    end

    // Backpressure with a competing in_valid while DONE.
    bus1.state_in = MIX_IN; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp_valid_rise", bus1.out_valid, 1'b1);
    bus1.state_in = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    bus1.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_out_valid", bus1.out_valid, 1'b1);
      check("bp_state_out", bus1.state_out, MIX_OUT);
      check("bp_in_ready", bus1.in_ready, 1'b0);
    end
    bus1.in_valid = 1'b0;
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    check("bp_accept_valid", bus1.out_valid, 1'b0);
    check("bp_accept_ready", bus1.in_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_capture", bus1.busy, 1'b0);

    // Reset after columns 0 and 1 have been processed.
    bus1.state_in = MIX_IN; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mrst_in_ready", bus1.in_ready, 1'b1);
    check("mrst_out_valid", bus1.out_valid, 1'b0);
    check("mrst_state_out", bus1.state_out, '0);
    check("mrst_busy", bus1.busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("mrst_no_output", bus1.out_valid, 1'b0);
    run_block(MIX_IN, dout, lat);
    check("mrst_next_block", dout, MIX_OUT);
    check("mrst_next_lat", lat, 4);

    // Back-to-back stream with out_ready tied high.
    for (int i = 0; i < 4; i++) begin
      bb_in[i]  = {4{sv_in[i]}};
      bb_exp[i] = {4{sv_out[i]}};
    end
    bb_in[4] = MIX_IN; bb_exp[4] = MIX_OUT;
    bus1.out_ready = 1'b1;
    bus1.state_in = bb_in[0];
    bus1.in_valid = 1'b1;
    in_idx = 0; out_idx = 0; cyc = 0; last_cyc = 0;
    while (out_idx < 5 && cyc < 100) begin
      hs   = bus1.in_valid & bus1.in_ready;
      acc  = bus1.out_valid & bus1.out_ready;
      snap = bus1.state_out;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        in_idx++;
        if (in_idx < 5) bus1.state_in = bb_in[in_idx];
        else bus1.in_valid = 1'b0;
      end
      if (acc) begin
        check($sformatf("bb_data%0d", out_idx), snap, bb_exp[out_idx]);
        if (out_idx > 0) check("bb_period", cyc - last_cyc, 6);
        last_cyc = cyc;
        out_idx++;
      end
    end
    check("bb_count", out_idx, 5);
    repeat (8) begin
      @(posedge clk); #1;
      check("bb_no_dup", bus1.out_valid, 1'b0);
    end
    bus1.out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
